// File: rtl/fb_pkg.sv
// Shared types and default sizes for the framebuffer controller and its bank RAMs.
package fb_pkg;

  typedef enum logic [1:0] {
    ACCEPT,
    SWAP_PENDING,
    COPY
  } fb_state_e;

  localparam int FB_ADDR_W = 8;
  localparam int FB_DATA_W = 16;
  localparam int FB_PIX    = 256;

endpackage

// File: rtl/framebuffer_ctrl_if.sv
// Host pixel-write bus: valid/ready handshake carrying panel select, address and data.
interface framebuffer_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              i_wr_valid;
  logic              o_wr_ready;
  logic              i_wr_panel;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;

  modport master (
    output i_wr_valid,
    output i_wr_panel,
    output i_wr_addr,
    output i_wr_data,
    input  o_wr_ready
  );

  modport slave (
    input  i_wr_valid,
    input  i_wr_panel,
    input  i_wr_addr,
    input  i_wr_data,
    output o_wr_ready
  );

endinterface

// File: rtl/fb_bank_ram.sv
// One pixel bank: single write port and a registered read port; storage is never reset.
module fb_bank_ram
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [1 << ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register only updates on a read, so the output holds between reads.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/framebuffer_ctrl.sv
// Double-buffered two-panel pixel store: host writes the back bank, the scanner reads the front,
// banks swap on a frame boundary and the new back bank is optionally refreshed from the front.
module framebuffer_ctrl
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter bit COPY_ON_SWAP = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  framebuffer_ctrl_if.slave io_wr,
  input  logic              i_swap_req,
  output logic              o_swap_ack,
  output logic              o_front_bank,
  input  logic              i_frame_done,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_raddr_1,
  output logic [DATA_W-1:0] o_rdata_1,
  input  logic [ADDR_W-1:0] i_raddr_2,
  output logic [DATA_W-1:0] o_rdata_2,
  output logic [15:0]       o_frame_count
);

  fb_state_e         r_state;
  logic              r_front;
  logic              r_swap_ack;
  logic [15:0]       r_frame_cnt;
  logic [ADDR_W:0]   r_copy_cnt;
  logic              r_copy_vld_p1;
  logic [ADDR_W-1:0] r_copy_addr_p1;
  logic              r_copy_last_p2;
  logic              r_rd_bank_p1;

  logic              w_wr_acc;
  logic              w_copy_rd;
  logic              w_front_re;
  logic [ADDR_W-1:0] w_copy_raddr;

  logic              w_we    [2][2];
  logic [ADDR_W-1:0] w_waddr [2][2];
  logic [DATA_W-1:0] w_wdata [2][2];
  logic              w_re    [2][2];
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_dout  [2][2];

  assign w_wr_acc     = io_wr.i_wr_valid && (r_state == ACCEPT);
  // The copy engine only borrows the front read port when the scanner leaves it idle.
  assign w_copy_rd    = (r_state == COPY) && !r_copy_cnt[ADDR_W] && !i_rd_en;
  assign w_front_re   = i_rd_en || w_copy_rd;
  assign w_copy_raddr = r_copy_cnt[ADDR_W-1:0];

  assign w_raddr[0] = i_rd_en ? i_raddr_1 : w_copy_raddr;
  assign w_raddr[1] = i_rd_en ? i_raddr_2 : w_copy_raddr;

  // p0: front-bank read (scanner or copy); p1: copy write into the back bank
  for (genvar p = 0; p < 2; p++) begin : g_panel
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic w_is_front;
      assign w_is_front    = (r_front == 1'(b));
      assign w_we[p][b]    = !w_is_front &&
                             (r_copy_vld_p1 || (w_wr_acc && (io_wr.i_wr_panel == 1'(p))));
      assign w_waddr[p][b] = r_copy_vld_p1 ? r_copy_addr_p1 : io_wr.i_wr_addr;
      // Copy data is the front bank's read register, sampled before a scanner read can replace it.
      assign w_wdata[p][b] = r_copy_vld_p1 ? w_dout[p][1-b] : io_wr.i_wr_data;
      assign w_re[p][b]    = w_is_front && w_front_re;

      fb_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
      ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we[p][b]),
        .i_waddr (w_waddr[p][b]),
        .i_wdata (w_wdata[p][b]),
        .i_re    (w_re[p][b]),
        .i_raddr (w_raddr[p]),
        .o_rdata (w_dout[p][b])
      );
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_copy_rd) r_copy_addr_p1 <= w_copy_raddr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ACCEPT;
      r_front        <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_frame_cnt    <= '0;
      r_copy_cnt     <= '0;
      r_copy_vld_p1  <= 1'b0;
      r_copy_last_p2 <= 1'b0;
      r_rd_bank_p1   <= 1'b0;
    end else begin
      r_swap_ack     <= 1'b0;
      r_copy_vld_p1  <= w_copy_rd;
      r_copy_last_p2 <= r_copy_vld_p1 && (r_copy_addr_p1 == '1);
      if (i_frame_done) r_frame_cnt  <= r_frame_cnt + 16'd1;
      if (w_front_re)   r_rd_bank_p1 <= r_front;
      if (w_copy_rd)    r_copy_cnt   <= r_copy_cnt + (ADDR_W+1)'(1);
      case (r_state)
        ACCEPT: begin
          if (i_swap_req) r_state <= SWAP_PENDING;
        end
        SWAP_PENDING: begin
          if (i_frame_done) begin
            r_front    <= ~r_front;
            r_swap_ack <= 1'b1;
            r_copy_cnt <= '0;
            r_state    <= COPY_ON_SWAP ? COPY : ACCEPT;
          end
        end
        // p2: the write of the last address has landed
        COPY: begin
          if (r_copy_last_p2) r_state <= ACCEPT;
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  assign io_wr.o_wr_ready = (r_state == ACCEPT);
  assign o_swap_ack       = r_swap_ack;
  assign o_front_bank     = r_front;
  assign o_frame_count    = r_frame_cnt;
  assign o_rdata_1        = w_dout[0][r_rd_bank_p1];
  assign o_rdata_2        = w_dout[1][r_rd_bank_p1];

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench for framebuffer_ctrl: scanner reads are checked by a queue-driven monitor,
// control outputs by inline comparisons against hand-derived values.
module tb_framebuffer_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        swap_req, swap_ack, front_bank, frame_done, rd_en;
  logic [7:0]  raddr_1, raddr_2;
  logic [15:0] rdata_1, rdata_2, frame_count;

  always #5 clk = ~clk;

  framebuffer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

  framebuffer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .COPY_ON_SWAP(1'b1)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .io_wr         (wr_if),
    .i_swap_req    (swap_req),
    .o_swap_ack    (swap_ack),
    .o_front_bank  (front_bank),
    .i_frame_done  (frame_done),
    .i_rd_en       (rd_en),
    .i_raddr_1     (raddr_1),
    .o_rdata_1     (rdata_1),
    .i_raddr_2     (raddr_2),
    .o_rdata_2     (rdata_2),
    .o_frame_count (frame_count)
  );

  typedef struct packed {
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] e1;
    logic [15:0] e2;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [15:0] mdl [2][2][256];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        exp_front = 1'b0;
  logic [15:0] exp_fc = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wr(input int p, input int a, input logic [15:0] d);
    int bi = exp_front ? 0 : 1;
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_panel = p[0];
    wr_if.i_wr_addr  = a[7:0];
    wr_if.i_wr_data  = d;
    tick();
    mdl[p][bi][a] = d;
  endtask

  task automatic rd(input int a1, input int a2);
    rd_exp_t e;
    int fi = exp_front ? 1 : 0;
    rd_en   = 1'b1;
    raddr_1 = a1[7:0];
    raddr_2 = a2[7:0];
    e.a1 = a1[7:0];
    e.a2 = a2[7:0];
    e.e1 = mdl[0][fi][a1];
    e.e2 = mdl[1][fi][a2];
    exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic copy_model(input int src);
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 256; a++)
        mdl[p][1-src][a] = mdl[p][src][a];
  endtask

  task automatic wait_copy(input string nm, input int exp_lat);
    int n = 0;
    while (wr_if.o_wr_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, n, exp_lat);
  endtask

  // Scoreboard monitor: a read issued in one cycle is compared at the next falling edge.
  initial begin
    logic    pend;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      pend = rd_en;
      @(negedge clk);
      if (pend) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_unexpected: got %04h/%04h, expected no read data", rdata_1, rdata_2);
        end else begin
          e = exp_q.pop_front();
          if (rdata_1 !== e.e1 || rdata_2 !== e.e2) begin
            n_bad++;
            $display("FAIL rd_data @%02h/%02h: got %04h/%04h, expected %04h/%04h",
                     e.a1, e.a2, rdata_1, rdata_2, e.e1, e.e2);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    swap_req = 0; frame_done = 0; rd_en = 0; raddr_1 = 0; raddr_2 = 0;
    wr_if.i_wr_valid = 0; wr_if.i_wr_panel = 0; wr_if.i_wr_addr = 0; wr_if.i_wr_data = 0;

    repeat (3) tick();
    chk("rst_front", front_bank, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_rdata1", rdata_1, 0);
    chk("rst_rdata2", rdata_2, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_ready", wr_if.o_wr_ready, 1);
    rst_n = 1;
    tick();

    // Fill back bank 1, then the single-pixel write from the reset-then-write scenario.
    for (int a = 0; a < 256; a++) begin
      wr(0, a, 16'(a));
      wr(1, a, 16'hA500 ^ 16'(a));
    end
    wr(0, 'h10, 16'hBEEF);
    wr_if.i_wr_valid = 0;
    tick();

    // Request coinciding with frame_done must wait for the next frame boundary.
    swap_req = 1; frame_done = 1;
    tick();
    swap_req = 0; frame_done = 0; exp_fc++;
    chk("same_cycle_ack", swap_ack, 0);
    chk("same_cycle_front", front_bank, 0);
    chk("pending_ready", wr_if.o_wr_ready, 0);
    chk("fc_1", frame_count, exp_fc);
    tick();
    chk("pending_ack", swap_ack, 0);
    swap_req = 1;
    tick();
    swap_req = 0;
    chk("pending_ready2", wr_if.o_wr_ready, 0);
    frame_done = 1;
    tick();
    frame_done = 0; exp_fc++; exp_front = 1; copy_model(1);
    chk("swap_ack", swap_ack, 1);
    chk("swap_front", front_bank, 1);
    chk("copy_ready", wr_if.o_wr_ready, 0);
    chk("fc_2", frame_count, exp_fc);
    tick();
    chk("ack_one_cycle", swap_ack, 0);
    chk("copy_ready2", wr_if.o_wr_ready, 0);
    wait_copy("copy_lat_idle", 257);
    rd('h10, 'h10);
    chk("ready_after_copy", wr_if.o_wr_ready, 1);

    // Swap back and read every address: front bank 0 must hold the copied data.
    swap_req = 1; tick(); swap_req = 0;
    frame_done = 1; tick(); frame_done = 0;
    exp_fc++; exp_front = 0; copy_model(0);
    chk("swap2_ack", swap_ack, 1);
    chk("swap2_front", front_bank, 0);
    tick();
    wait_copy("copy_lat_idle2", 257);
    for (int a = 0; a < 256; a++) rd(a, 255 - a);

    // New pattern into back bank 1, then swap under scanner contention and host backpressure.
    for (int a = 0; a < 256; a++) begin
      wr(0, a, 16'hC300 | 16'(a));
      wr(1, a, 16'h5A00 | 16'(255 - a));
    end
    wr_if.i_wr_valid = 0;
    swap_req = 1; tick(); swap_req = 0;
    wr_if.i_wr_valid = 1; wr_if.i_wr_panel = 1; wr_if.i_wr_addr = 8'h33; wr_if.i_wr_data = 16'hD00D;
    chk("bp_ready_pending", wr_if.o_wr_ready, 0);
    tick(); tick();
    frame_done = 1; tick(); frame_done = 0;
    exp_fc++; exp_front = 1; copy_model(1);
    chk("swap3_ack", swap_ack, 1);
    n = 0;
    while (wr_if.o_wr_ready !== 1'b1 && n < 2000) begin
      if (n % 2 == 1) rd((n / 2) & 255, (n * 7) & 255);
      else tick();
      n++;
    end
    chk("copy_lat_contend", n, 513);
    tick();
    mdl[1][0]['h33] = 16'hD00D;
    wr_if.i_wr_valid = 0;

    swap_req = 1; tick(); swap_req = 0;
    frame_done = 1; tick(); frame_done = 0;
    exp_fc++; exp_front = 0; copy_model(0);
    chk("swap4_front", front_bank, 0);
    chk("fc_4", frame_count, exp_fc);
    tick();
    wait_copy("copy_lat_idle3", 257);
    for (int a = 0; a < 256; a++) rd(a, a);

    // Reset while the copy engine is at address 100.
    swap_req = 1; tick(); swap_req = 0;
    frame_done = 1; tick(); frame_done = 0;
    chk("swap5_front", front_bank, 1);
    repeat (100) tick();
    chk("midcopy_ready", wr_if.o_wr_ready, 0);
    rst_n = 0;
    tick();
    exp_front = 0; exp_fc = '0;
    chk("rst_mid_front", front_bank, 0);
    chk("rst_mid_ready", wr_if.o_wr_ready, 1);
    chk("rst_mid_fc", frame_count, 0);
    chk("rst_mid_ack", swap_ack, 0);
    chk("rst_mid_rdata1", rdata_1, 0);
    rst_n = 1;
    tick(); tick();
    chk("post_rst_ready", wr_if.o_wr_ready, 1);
    rd('h33, 'h33);
    rd(0, 255);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
